// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for alu_arbiter: ALU opcodes, FSM state encoding
// and the long-op classifier used when ALU_ARB_LONGOP_EN is defined.
package alu_arbiter_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_DIV  = 4'd11;
  localparam logic [3:0] OP_MOD  = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // MUL/DIV/MOD are the ops that get a multicycle execution window.
  function automatic logic is_long_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu.sv
// Shared combinational ALU. Compare results are zero-extended; division
// by zero yields 0 here and is overridden by the arbiter.
module alu
  import alu_arbiter_pkg::*;
#(
  parameter int WORD_SIZE = 64
) (
  input  logic [WORD_SIZE-1:0] a_i,
  input  logic [WORD_SIZE-1:0] b_i,
  input  logic [3:0]           op_i,
  output logic [WORD_SIZE-1:0] result_o
);

  localparam int SW = $clog2(WORD_SIZE);

  logic [SW-1:0] shamt;
  assign shamt = b_i[SW-1:0];

  // Opcode decode into the selected result.
  always_comb begin
    result_o = '0;
    case (op_i)
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_SLL:  result_o = a_i << shamt;
      OP_SRL:  result_o = a_i >> shamt;
      OP_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
      OP_SLT:  result_o = {{(WORD_SIZE-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_SLTU: result_o = {{(WORD_SIZE-1){1'b0}}, (a_i < b_i)};
      OP_MUL:  result_o = a_i * b_i;
      OP_DIV:  result_o = (b_i == '0) ? '0 : a_i / b_i;
      OP_MOD:  result_o = (b_i == '0) ? '0 : a_i % b_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of valid at or above
// ptr, wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] grant_o,
  output logic          any_o
);

  logic [2*N-1:0] rot;
  int             g;

  // Rotate so bit 0 is the pointer position, then take the first hit.
  always_comb begin
    rot     = {valid_i, valid_i} >> ptr_i;
    grant_o = '0;
    any_o   = 1'b0;
    g       = 0;
    for (int k = 0; k < N; k++) begin
      if (!any_o && rot[k]) begin
        any_o = 1'b1;
        g     = int'(ptr_i) + k;
        if (g >= N) g = g - N;
        grant_o = IW'(g);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one ALU between NUM_REQ requesters.
// Valid/ready: a transfer happens on a rising edge where valid and ready
// are both high; the source holds its payload stable until then.
// Optional feature macro: ALU_ARB_LONGOP_EN (MUL/DIV/MOD take LONG_LAT
// EXEC cycles instead of one).
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WORD_SIZE = 64,
  parameter int NUM_REQ   = 4,
  parameter int LONG_LAT  = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*WORD_SIZE-1:0] req_a,
  input  logic [NUM_REQ*WORD_SIZE-1:0] req_b,
  input  logic [NUM_REQ*4-1:0]         req_op,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [IW-1:0]                resp_id,
  output logic [WORD_SIZE-1:0]         resp_data,
  output logic [1:0]                   dbg_state_o
);

  localparam int CW = (LONG_LAT > 1) ? $clog2(LONG_LAT) : 1;

  state_t               state_q, state_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WORD_SIZE-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
  logic [3:0]           op_q, op_d;
  logic [IW-1:0]        id_q, id_d;

  logic [IW-1:0]        grant;
  logic                 any;
  logic [3:0]           op_sel;
  logic [CW-1:0]        cnt_load;
  logic [WORD_SIZE-1:0] alu_res, exec_res;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .any_o   (any)
  );

  alu #(.WORD_SIZE(WORD_SIZE)) u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .op_i     (op_q),
    .result_o (alu_res)
  );

  assign op_sel = req_op[grant*4 +: 4];

  // EXEC length for the op being accepted.
  always_comb begin
`ifdef ALU_ARB_LONGOP_EN
    cnt_load = is_long_op(op_sel) ? CW'(LONG_LAT - 1) : '0;
`else
    cnt_load = '0;
`endif
  end

  // Divide/modulo by zero results are defined here, not by the ALU.
  always_comb begin
    exec_res = alu_res;
    if (b_q == '0) begin
      if (op_q == OP_DIV) exec_res = '1;
      else if (op_q == OP_MOD) exec_res = a_q;
    end
  end

  // FSM next-state, operand latching and request handshake.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    id_d      = id_q;
    data_d    = data_q;
    req_ready = '0;
    case (state_q)
      S_IDLE: begin
        if (any) begin
          req_ready[grant] = 1'b1;
          a_d     = req_a[grant*WORD_SIZE +: WORD_SIZE];
          b_d     = req_b[grant*WORD_SIZE +: WORD_SIZE];
          op_d    = op_sel;
          id_d    = grant;
          cnt_d   = cnt_load;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q == '0) begin
          data_d  = exec_res;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          rr_ptr_d = (id_q == IW'(NUM_REQ - 1)) ? '0 : id_q + IW'(1);
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      id_q     <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      id_q     <= id_d;
      data_q   <= data_d;
    end
  end

  assign resp_valid  = (state_q == S_RESP);
  assign resp_id     = id_q;
  assign resp_data   = data_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter. Inputs change just after the falling
// edge; outputs are sampled 1ns later, well away from the rising edge.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int W  = 64;
  localparam int N  = 4;
  localparam int IW = 2;
`ifdef ALU_ARB_LONGOP_EN
  localparam int LONG_LATENCY = 5;
`else
  localparam int LONG_LATENCY = 2;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N*4-1:0] req_op = '0;
  logic           resp_valid;
  logic           resp_ready = 1'b1;
  logic [IW-1:0]  resp_id;
  logic [W-1:0]   resp_data;
  logic [1:0]     dbg_state;

  alu_arbiter #(.WORD_SIZE(W), .NUM_REQ(N), .LONG_LAT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_data   (resp_data),
    .dbg_state_o (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [N-1:0] exp_grant_q[$];
  logic [IW-1:0] exp_id_q[$];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] op);
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
    req_op[idx*4 +: 4] = op;
    req_valid[idx] = 1'b1;
  endtask

  // One transaction with resp_ready high: checks grant, latency, data, id.
  task automatic run_op(input string tag, input int idx, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [3:0] op,
                        input logic [W-1:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    set_req(idx, a, b, op);
    #1;
    check({tag, "_ready"}, W'(req_ready), W'(1 << idx));
    @(negedge clk);
    req_valid = '0;
    #1;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, W'(lat), W'(exp_lat));
    check({tag, "_data"}, resp_data, exp);
    check({tag, "_id"}, W'(resp_id), W'(idx));
  endtask

  int cyc_last;
  int n_acc;
  int n_resp;
  logic stop_pending;

  initial begin
    // ---- reset state ----
    repeat (2) @(negedge clk);
    #1;
    check("rst_resp_valid", W'(resp_valid), '0);
    check("rst_resp_data", resp_data, '0);
    check("rst_resp_id", W'(resp_id), '0);
    check("rst_req_ready", W'(req_ready), '0);
    @(negedge clk);
    rst = 1'b0;

    // ---- single requester 1: ADD 5+7, latency 2, ptr moves to 2 ----
    run_op("add1", 1, 64'd5, 64'd7, OP_ADD, 64'd12, 2);

    // ---- reset one cycle after accepting ADD from requester 3 ----
    @(negedge clk);
    set_req(3, 64'd5, 64'd7, OP_ADD);
    #1;
    check("mid_ready", W'(req_ready), W'(4'b1000));
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", W'(resp_valid), '0);
    check("mid_rst_data", resp_data, '0);
    check("mid_rst_id", W'(resp_id), '0);
    check("mid_rst_ready", W'(req_ready), '0);
    check("mid_rst_state", W'(dbg_state), W'(S_IDLE));
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("mid_no_resp", W'(resp_valid), '0);
    end

    // ---- all four valid: grants 0,1,2,3,0 every 3 cycles ----
    for (int i = 0; i < N; i++) set_req(i, W'(100 + i), W'(i), OP_ADD);
    exp_grant_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_q       = '{64'd100, 64'd102, 64'd104, 64'd106, 64'd100};
    exp_id_q    = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    cyc_last = -1;
    n_acc = 0;
    n_resp = 0;
    stop_pending = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (stop_pending) req_valid = '0;
      #1;
      if (req_ready != '0) begin
        if (exp_grant_q.size() > 0) check("rr_grant", W'(req_ready), W'(exp_grant_q.pop_front()));
        else check("rr_extra_grant", W'(req_ready), '0);
        if (cyc_last >= 0) check("rr_gap", W'(cyc - cyc_last), W'(3));
        cyc_last = cyc;
        n_acc++;
        if (n_acc == 5) stop_pending = 1'b1;
      end
      if (resp_valid) begin
        if (exp_q.size() > 0) begin
          check("rr_data", resp_data, exp_q.pop_front());
          check("rr_id", W'(resp_id), W'(exp_id_q.pop_front()));
        end else begin
          check("rr_extra_resp", W'(resp_valid), '0);
        end
        n_resp++;
      end
    end
    check("rr_n_acc", W'(n_acc), W'(5));
    check("rr_n_resp", W'(n_resp), W'(5));

    // ---- back-pressure: SUB 10-3 held 5 cycles, req 0 waits ----
    resp_ready = 1'b0;
    @(negedge clk);
    set_req(2, 64'd10, 64'd3, OP_SUB);
    #1;
    check("bp_ready", W'(req_ready), W'(4'b0100));
    @(negedge clk);
    req_valid = '0;
    set_req(0, 64'd1, 64'd1, OP_ADD);
    #1;
    check("bp_exec_ready", W'(req_ready), '0);
    @(negedge clk);
    #1;
    check("bp_valid", W'(resp_valid), 1);
    check("bp_id", W'(resp_id), 2);
    repeat (5) begin
      @(negedge clk);
      #1;
      check("bp_hold_valid", W'(resp_valid), 1);
      check("bp_hold_data", resp_data, 64'd7);
      check("bp_hold_ready", W'(req_ready), '0);
    end
    resp_ready = 1'b1;
    #1;
    check("bp_hs_ready", W'(req_ready), '0);
    @(negedge clk);
    #1;
    check("bp_resume_ready", W'(req_ready), W'(4'b0001));
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    check("bp_resume_data", resp_data, 64'd2);
    check("bp_resume_id", W'(resp_id), 0);

    // ---- divide/modulo by zero and assorted ops ----
    run_op("div0", 1, 64'd100, 64'd0, OP_DIV, '1, LONG_LATENCY);
    run_op("mod0", 1, 64'd9, 64'd0, OP_MOD, 64'd9, LONG_LATENCY);
    run_op("div", 2, 64'd100, 64'd7, OP_DIV, 64'd14, LONG_LATENCY);
    run_op("mod", 3, 64'd100, 64'd7, OP_MOD, 64'd2, LONG_LATENCY);
    run_op("mul", 0, 64'd6, 64'd7, OP_MUL, 64'd42, LONG_LATENCY);
    run_op("xor", 1, 64'hF0, 64'h3C, OP_XOR, 64'hCC, 2);
    run_op("slt", 2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, OP_SLT, 64'd1, 2);
    run_op("sltu", 3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, OP_SLTU, 64'd0, 2);
    run_op("sra", 0, 64'h8000_0000_0000_0000, 64'd4, OP_SRA, 64'hF800_0000_0000_0000, 2);

    // ---- final report ----
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
